// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - MIPS 5-stage hazard unit with MUL/DIV busy tracking and syscall drain
// Forwarding and stall terms are combinational; MDU, drain FSM and stall counter are registered.
module hazard_unit_mc #(
  parameter int REG_AW    = 5,
  parameter int MDU_LAT   = 4,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              BranchD,
  input  logic              MemtoRegE,
  input  logic              RegWriteE,
  input  logic              MemtoRegM,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              MduStartE,
  input  logic              MduUseD,
  input  logic              SyscallD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MduBusy,
  output logic              SyscallGo,
  output logic [CNT_W-1:0]  StallCnt
);

  localparam int MW = $clog2(MDU_LAT);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_GO} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [MW-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lw_stall, br_stall, md_stall, sc_stall, dr_stall, stall;

  assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
  assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

  always_comb begin
    ForwardAE = 2'b00;
    if ((RsE != '0) && (RsE == WriteRegM) && RegWriteM)      ForwardAE = 2'b10;
    else if ((RsE != '0) && (RsE == WriteRegW) && RegWriteW) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if ((RtE != '0) && (RtE == WriteRegM) && RegWriteM)      ForwardBE = 2'b10;
    else if ((RtE != '0) && (RtE == WriteRegW) && RegWriteW) ForwardBE = 2'b01;
  end

  assign lw_stall = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
  assign br_stall = BranchD &&
                    ((RegWriteE && (WriteRegE != '0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                     (MemtoRegM && (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));
  assign md_stall = MduUseD && MduBusy;
  // In IDLE a pending syscall stalls both while the MDU drains and on the cycle it enters DRAIN.
  assign sc_stall = SyscallD && (state_q == S_IDLE);
  assign dr_stall = (state_q == S_DRAIN);
  assign stall    = !reset && (lw_stall || br_stall || md_stall || sc_stall || dr_stall);

  assign StallF    = stall;
  assign StallD    = stall;
  assign FlushE    = stall;
  assign MduBusy   = (mdu_cnt_q != '0);
  assign SyscallGo = (state_q == S_GO);
  assign StallCnt  = stall_cnt_q;

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (MduStartE && (mdu_cnt_q == '0)) mdu_cnt_d = MW'(MDU_LAT - 1);
    else if (mdu_cnt_q != '0)           mdu_cnt_d = mdu_cnt_q - 1'b1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (SyscallD && !MduBusy) begin
          state_d = S_DRAIN;
          dcnt_d  = DW'(DRAIN_CYC - 1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == '0) state_d = S_GO;
        else              dcnt_d  = dcnt_q - 1'b1;
      end
      S_GO:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dcnt_q      <= '0;
      mdu_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - self-checking bench for hazard_unit_mc
// Vector table, hand sequences for MDU/syscall/reset/saturation, and a randomized run against a timeline model.
module tb_hazard_unit_mc;

  localparam int AW = 5, LAT = 4, DC = 3, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic BranchD, MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW;
  logic [AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic MduStartE, MduUseD, SyscallD;
  logic StallF, StallD, FlushE, ForwardAD, ForwardBD, MduBusy, SyscallGo;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] StallCnt;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(AW), .MDU_LAT(LAT), .DRAIN_CYC(DC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .BranchD(BranchD), .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
    .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .MduStartE(MduStartE), .MduUseD(MduUseD), .SyscallD(SyscallD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MduBusy(MduBusy), .SyscallGo(SyscallGo),
    .StallCnt(StallCnt)
  );

  typedef struct {
    int mE, rwE, mM, rwM, rwW, br;
    int rsD, rtD, rsE, rtE, wE, wM, wW;
    int st, fad, fbd, fae, fbe;
  } vec_t;

  vec_t vt[11];
  int checks = 0, errors = 0;
  int exp_cnt = 0, cyc = 0, busy_end = 0;
  int last_stall = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic clear_inputs();
    BranchD = 0; MemtoRegE = 0; RegWriteE = 0; MemtoRegM = 0; RegWriteM = 0; RegWriteW = 0;
    RsD = '0; RtD = '0; RsE = '0; RtE = '0; WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    MduStartE = 0; MduUseD = 0; SyscallD = 0;
  endtask

  task automatic drive_check(input int es, input int eg, input int eb, input string nm);
    #1;
    chk({nm, " StallF"}, int'(StallF), es);
    chk({nm, " StallD"}, int'(StallD), es);
    chk({nm, " FlushE"}, int'(FlushE), es);
    chk({nm, " SyscallGo"}, int'(SyscallGo), eg);
    chk({nm, " MduBusy"}, int'(MduBusy), eb);
    chk({nm, " StallCnt"}, int'(StallCnt), exp_cnt);
    last_stall = es;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset && last_stall != 0 && exp_cnt < CMAX) exp_cnt++;
    cyc++;
    @(negedge clk);
  endtask

  function automatic int ref_fe(input logic [AW-1:0] r);
    if (r != 0 && r == WriteRegM && RegWriteM) return 2;
    if (r != 0 && r == WriteRegW && RegWriteW) return 1;
    return 0;
  endfunction

  function automatic int ref_fd(input logic [AW-1:0] r);
    return (r != 0 && r == WriteRegM && RegWriteM) ? 1 : 0;
  endfunction

  function automatic int ref_hazard();
    int lw, brs;
    lw  = (MemtoRegE && RtE != 0 && (RtE == RsD || RtE == RtD)) ? 1 : 0;
    brs = (BranchD && ((RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                       (MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD)))) ? 1 : 0;
    return lw | brs;
  endfunction

  task automatic check_fwd(input string nm);
    chk({nm, " ForwardAD"}, int'(ForwardAD), ref_fd(RsD));
    chk({nm, " ForwardBD"}, int'(ForwardBD), ref_fd(RtD));
    chk({nm, " ForwardAE"}, int'(ForwardAE), ref_fe(RsE));
    chk({nm, " ForwardBE"}, int'(ForwardBE), ref_fe(RtE));
  endtask

  initial begin
    int md_start[6] = '{1, 0, 1, 0, 0, 0};
    int md_use[6]   = '{1, 1, 1, 1, 1, 0};
    int md_st[6]    = '{0, 1, 1, 1, 0, 0};
    int md_busy[6]  = '{0, 1, 1, 1, 0, 0};
    int sc_start[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int sc_sys[10]   = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    int sc_st[10]    = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
    int sc_go[10]    = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int sc_busy[10]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0};

    //           mE rwE mM rwM rwW br  rsD rtD rsE rtE wE  wM  wW  st fad fbd fae fbe
    vt[0]  = '{1, 0, 0, 0, 0, 0,  4,  0,  0,  4,  0,  0,  0, 1, 0, 0, 0, 0};
    vt[1]  = '{1, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0, 0};
    vt[2]  = '{0, 1, 0, 0, 0, 1, 16,  0,  0,  0, 16,  0,  0, 1, 0, 0, 0, 0};
    vt[3]  = '{0, 0, 1, 0, 0, 1,  0, 16,  0,  0,  0, 16,  0, 1, 0, 0, 0, 0};
    vt[4]  = '{0, 0, 0, 1, 1, 0,  0,  0,  5,  0,  0,  5,  5, 0, 0, 0, 2, 0};
    vt[5]  = '{0, 0, 0, 0, 1, 0,  0,  0,  5,  0,  0,  5,  5, 0, 0, 0, 1, 0};
    vt[6]  = '{0, 0, 0, 1, 0, 0,  7,  7,  0,  0,  0,  7,  0, 0, 1, 1, 0, 0};
    vt[7]  = '{0, 1, 1, 1, 1, 1,  0,  0,  0,  0,  0,  0,  0, 0, 0, 0, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 1, 0,  0,  0,  0,  9,  0,  9,  9, 0, 0, 0, 0, 1};
    vt[9]  = '{0, 0, 0, 0, 0, 1,  3,  0,  0,  0,  3,  0,  0, 0, 0, 0, 0, 0};
    vt[10] = '{1, 0, 0, 0, 0, 0,  0,  6,  0,  6,  0,  0,  0, 1, 0, 0, 0, 0};

    // Reset held with every stall source and an MDU start active.
    clear_inputs();
    reset = 1;
    SyscallD = 1; MemtoRegE = 1; RtE = 5'd4; RsD = 5'd4; MduStartE = 1;
    RsE = 5'd5; WriteRegM = 5'd5; RegWriteM = 1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      drive_check(0, 0, 0, "reset");
      chk("reset ForwardAE", int'(ForwardAE), 2);
      tick();
    end
    reset = 0;
    clear_inputs();
    drive_check(0, 0, 0, "post_reset");
    tick();

    for (int i = 0; i < 11; i++) begin
      MemtoRegE = vt[i].mE[0]; RegWriteE = vt[i].rwE[0]; MemtoRegM = vt[i].mM[0];
      RegWriteM = vt[i].rwM[0]; RegWriteW = vt[i].rwW[0]; BranchD = vt[i].br[0];
      RsD = AW'(vt[i].rsD); RtD = AW'(vt[i].rtD); RsE = AW'(vt[i].rsE); RtE = AW'(vt[i].rtE);
      WriteRegE = AW'(vt[i].wE); WriteRegM = AW'(vt[i].wM); WriteRegW = AW'(vt[i].wW);
      drive_check(vt[i].st, 0, 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d ForwardAD", i), int'(ForwardAD), vt[i].fad);
      chk($sformatf("vec%0d ForwardBD", i), int'(ForwardBD), vt[i].fbd);
      chk($sformatf("vec%0d ForwardAE", i), int'(ForwardAE), vt[i].fae);
      chk($sformatf("vec%0d ForwardBE", i), int'(ForwardBE), vt[i].fbe);
      tick();
    end
    clear_inputs();

    // MDU busy window with a second start mid-busy.
    for (int i = 0; i < 6; i++) begin
      MduStartE = md_start[i][0]; MduUseD = md_use[i][0];
      drive_check(md_st[i], 0, md_busy[i], $sformatf("mdu%0d", i));
      tick();
    end
    clear_inputs();

    // Syscall waiting on the MDU, then draining.
    for (int i = 0; i < 10; i++) begin
      MduStartE = sc_start[i][0]; SyscallD = sc_sys[i][0];
      drive_check(sc_st[i], sc_go[i], sc_busy[i], $sformatf("sys%0d", i));
      tick();
    end
    clear_inputs();

    // Reset asserted while the FSM is in DRAIN.
    SyscallD = 1;
    drive_check(1, 0, 0, "rd_idle");
    tick();
    drive_check(1, 0, 0, "rd_drain");
    MemtoRegE = 1; RtE = 5'd4; RsD = 5'd4;
    #1 reset = 1;
    exp_cnt = 0;
    drive_check(0, 0, 0, "rd_reset");
    tick();
    reset = 0;
    clear_inputs();
    drive_check(0, 0, 0, "rd_after");
    tick();

    // Randomized run against a timeline model of the MDU.
    busy_end = 0;
    for (int n = 0; n < 300; n++) begin
      int busy, es;
      BranchD = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
      RegWriteE = 1'($urandom_range(0, 1)); MemtoRegM = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      RsD = AW'($urandom_range(0, 3)); RtD = AW'($urandom_range(0, 3));
      RsE = AW'($urandom_range(0, 3)); RtE = AW'($urandom_range(0, 3));
      WriteRegE = AW'($urandom_range(0, 3)); WriteRegM = AW'($urandom_range(0, 3));
      WriteRegW = AW'($urandom_range(0, 3));
      MduStartE = ($urandom_range(0, 3) == 0); MduUseD = 1'($urandom_range(0, 1));
      busy = (cyc < busy_end) ? 1 : 0;
      es = ref_hazard() | ((MduUseD && busy != 0) ? 1 : 0);
      drive_check(es, 0, busy, "rand");
      check_fwd("rand");
      if (MduStartE && busy == 0) busy_end = cyc + LAT;
      tick();
    end
    clear_inputs();
    for (int i = 0; i < LAT; i++) begin
      drive_check(0, 0, (cyc < busy_end) ? 1 : 0, "rand_idle");
      tick();
    end

    // Stall counter saturation, then reset.
    reset = 1;
    exp_cnt = 0;
    tick();
    reset = 0;
    MemtoRegE = 1; RtE = 5'd4; RsD = 5'd4;
    for (int i = 0; i < 20; i++) begin
      drive_check(1, 0, 0, "sat");
      tick();
    end
    clear_inputs();
    #1 chk("sat final", int'(StallCnt), CMAX);
    reset = 1;
    exp_cnt = 0;
    #1 chk("sat reset", int'(StallCnt), 0);
    tick();
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
